// File: rtl/gate_box_pkg.sv
// Shared constants and types for gate_box: width limit and the registered result bundle.
package gate_box_pkg;

  localparam int GATE_BOX_MAX_WIDTH = 64;

  typedef struct packed {
    logic [GATE_BOX_MAX_WIDTH-1:0] nd;
    logic [GATE_BOX_MAX_WIDTH-1:0] r;
    logic [GATE_BOX_MAX_WIDTH-1:0] nnd;
    logic [GATE_BOX_MAX_WIDTH-1:0] nr;
    logic [GATE_BOX_MAX_WIDTH-1:0] xr;
    logic [GATE_BOX_MAX_WIDTH-1:0] nxr;
  } gate_res_t;

endpackage

// File: rtl/gate_box_lane.sv
// One-bit combinational slice of gate_box: all six two-input gate functions of a and b.
module gate_box_lane (
  input  logic a,
  input  logic b,
  output logic nd,
  output logic r,
  output logic nnd,
  output logic nr,
  output logic xr,
  output logic nxr
);

  assign nd  = a & b;
  assign r   = a | b;
  assign nnd = ~(a & b);
  assign nr  = ~(a | b);
  assign xr  = a ^ b;
  assign nxr = ~(a ^ b);

endmodule

// File: rtl/gate_box.sv
// Registered bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR), one-cycle latency with valid strobe.
// Define GATE_BOX_REDUCE_EN to add registered reduction outputs red_nd, red_r, red_xr.
module gate_box
  import gate_box_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] nd,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] nnd,
  output logic [WIDTH-1:0] nr,
  output logic [WIDTH-1:0] xr,
  output logic [WIDTH-1:0] nxr
`ifdef GATE_BOX_REDUCE_EN
  ,
  output logic             red_nd,
  output logic             red_r,
  output logic             red_xr
`endif
);

  logic [WIDTH-1:0] lane_nd, lane_r, lane_nnd, lane_nr, lane_xr, lane_nxr;
  gate_res_t        res_d;
  gate_res_t        res_q;
  logic             valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    gate_box_lane u_lane (
      .a   (a[i]),
      .b   (b[i]),
      .nd  (lane_nd[i]),
      .r   (lane_r[i]),
      .nnd (lane_nnd[i]),
      .nr  (lane_nr[i]),
      .xr  (lane_xr[i]),
      .nxr (lane_nxr[i])
    );
  end

  // Bits above WIDTH stay zero so the fixed-width bundle is well defined.
  always_comb begin
    res_d = '0;
    res_d.nd[WIDTH-1:0]  = lane_nd;
    res_d.r[WIDTH-1:0]   = lane_r;
    res_d.nnd[WIDTH-1:0] = lane_nnd;
    res_d.nr[WIDTH-1:0]  = lane_nr;
    res_d.xr[WIDTH-1:0]  = lane_xr;
    res_d.nxr[WIDTH-1:0] = lane_nxr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q <= res_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign nd        = res_q.nd[WIDTH-1:0];
  assign r         = res_q.r[WIDTH-1:0];
  assign nnd       = res_q.nnd[WIDTH-1:0];
  assign nr        = res_q.nr[WIDTH-1:0];
  assign xr        = res_q.xr[WIDTH-1:0];
  assign nxr       = res_q.nxr[WIDTH-1:0];

  // Upper bundle bits are constant zero and intentionally not brought out.
  logic unused_hi;
  assign unused_hi = ^res_q;

`ifdef GATE_BOX_REDUCE_EN
  logic red_nd_q, red_r_q, red_xr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      red_nd_q <= 1'b0;
      red_r_q  <= 1'b0;
      red_xr_q <= 1'b0;
    end else if (in_valid) begin
      red_nd_q <= &lane_nd;
      red_r_q  <= |lane_r;
      red_xr_q <= ^lane_xr;
    end
  end

  assign red_nd = red_nd_q;
  assign red_r  = red_r_q;
  assign red_xr = red_xr_q;
`endif

endmodule

// File: tb/tb_gate_box.sv
// Scoreboard bench for gate_box: three instances (WIDTH 1, 4, 8) fed from one 8-bit stimulus stream.
module tb_gate_box;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [7:0] a, b;

  logic       ov1, ov4, ov8;
  logic [0:0] nd1, r1, nnd1, nr1, xr1, nxr1;
  logic [3:0] nd4, r4, nnd4, nr4, xr4, nxr4;
  logic [7:0] nd8, r8, nnd8, nr8, xr8, nxr8;
  logic [2:0] red_nd, red_r, red_xr;

  gate_box #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
    .out_valid(ov1), .nd(nd1), .r(r1), .nnd(nnd1), .nr(nr1), .xr(xr1), .nxr(nxr1)
`ifdef GATE_BOX_REDUCE_EN
    , .red_nd(red_nd[0]), .red_r(red_r[0]), .red_xr(red_xr[0])
`endif
  );

  gate_box #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[3:0]), .b(b[3:0]),
    .out_valid(ov4), .nd(nd4), .r(r4), .nnd(nnd4), .nr(nr4), .xr(xr4), .nxr(nxr4)
`ifdef GATE_BOX_REDUCE_EN
    , .red_nd(red_nd[1]), .red_r(red_r[1]), .red_xr(red_xr[1])
`endif
  );

  gate_box #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(ov8), .nd(nd8), .r(r8), .nnd(nnd8), .nr(nr8), .xr(xr8), .nxr(nxr8)
`ifdef GATE_BOX_REDUCE_EN
    , .red_nd(red_nd[2]), .red_r(red_r[2]), .red_xr(red_xr[2])
`endif
  );

  typedef struct {
    logic       valid;
    logic [7:0] nd, r, nnd, nr, xr, nxr;
    logic [2:0] red_nd, red_r, red_xr;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Truth-table model: each bit is judged by how many of its two inputs are high.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t m;
    int   cnt;
    int   widths[3] = '{1, 4, 8};
    int   n_and, n_or, n_xor;
    m = '{default: '0};
    m.valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cnt = int'(x[i]) + int'(y[i]);
      m.nd[i]  = (cnt == 2);
      m.r[i]   = (cnt != 0);
      m.xr[i]  = (cnt == 1);
      m.nnd[i] = (cnt != 2);
      m.nr[i]  = (cnt == 0);
      m.nxr[i] = (cnt != 1);
    end
    for (int k = 0; k < 3; k++) begin
      n_and = 0; n_or = 0; n_xor = 0;
      for (int i = 0; i < widths[k]; i++) begin
        cnt = int'(x[i]) + int'(y[i]);
        if (cnt == 2) n_and++;
        if (cnt != 0) n_or++;
        if (cnt == 1) n_xor++;
      end
      m.red_nd[k] = (n_and == widths[k]);
      m.red_r[k]  = (n_or > 0);
      m.red_xr[k] = (n_xor % 2 == 1);
    end
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r_in, input logic v_in,
                               input logic [7:0] a_in, input logic [7:0] b_in);
    exp_t e;
    @(negedge clk);
    #1;
    rst      = r_in;
    in_valid = v_in;
    a        = a_in;
    b        = b_in;
    if (r_in) held = '{default: '0};
    else if (v_in) held = model(a_in, b_in);
    e = held;
    e.valid = !r_in && v_in;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("w1.out_valid", 64'(ov1), 64'(mon_e.valid));
      checkOutput("w1.nd",  64'(nd1),  64'(mon_e.nd[0:0]));
      checkOutput("w1.r",   64'(r1),   64'(mon_e.r[0:0]));
      checkOutput("w1.nnd", 64'(nnd1), 64'(mon_e.nnd[0:0]));
      checkOutput("w1.nr",  64'(nr1),  64'(mon_e.nr[0:0]));
      checkOutput("w1.xr",  64'(xr1),  64'(mon_e.xr[0:0]));
      checkOutput("w1.nxr", 64'(nxr1), 64'(mon_e.nxr[0:0]));
      checkOutput("w4.out_valid", 64'(ov4), 64'(mon_e.valid));
      checkOutput("w4.nd",  64'(nd4),  64'(mon_e.nd[3:0]));
      checkOutput("w4.r",   64'(r4),   64'(mon_e.r[3:0]));
      checkOutput("w4.nnd", 64'(nnd4), 64'(mon_e.nnd[3:0]));
      checkOutput("w4.nr",  64'(nr4),  64'(mon_e.nr[3:0]));
      checkOutput("w4.xr",  64'(xr4),  64'(mon_e.xr[3:0]));
      checkOutput("w4.nxr", 64'(nxr4), 64'(mon_e.nxr[3:0]));
      checkOutput("w8.out_valid", 64'(ov8), 64'(mon_e.valid));
      checkOutput("w8.nd",  64'(nd8),  64'(mon_e.nd));
      checkOutput("w8.r",   64'(r8),   64'(mon_e.r));
      checkOutput("w8.nnd", 64'(nnd8), 64'(mon_e.nnd));
      checkOutput("w8.nr",  64'(nr8),  64'(mon_e.nr));
      checkOutput("w8.xr",  64'(xr8),  64'(mon_e.xr));
      checkOutput("w8.nxr", 64'(nxr8), 64'(mon_e.nxr));
`ifdef GATE_BOX_REDUCE_EN
      checkOutput("red_nd", 64'(red_nd), 64'(mon_e.red_nd));
      checkOutput("red_r",  64'(red_r),  64'(mon_e.red_r));
      checkOutput("red_xr", 64'(red_xr), 64'(mon_e.red_xr));
`endif
    end else if (ov1 === 1'b1 || ov4 === 1'b1 || ov8 === 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL spurious_valid: got out_valid=%b%b%b expected 000 at %0t", ov1, ov4, ov8, $time);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    held     = '{default: '0};

    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h5A, 8'hC3);

    // Full truth table, replicated across every lane.
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'hFF);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'hFF);

    applyStimulus(1'b0, 1'b1, 8'h0C, 8'h0A);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 8'($urandom), 8'($urandom));

    applyStimulus(1'b0, 1'b1, 8'h0F, 8'h0F);
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'hFF);

    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF);
    applyStimulus(1'b0, 1'b1, 8'h96, 8'h3C);

    for (int i = 0; i < 1000; i++)
      applyStimulus(1'b0, 1'b1, 8'($urandom), 8'($urandom));

    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                    8'($urandom), 8'($urandom));

    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    #2;
    checkOutput("drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
